// File: rtl/uart_sched_pkg.sv
// Shared types and register-map constants for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POLL_RD,
        POLL_CHK,
        GAP,
        WR_BUF,
        WR_CTL
    } state_t;

    localparam logic [7:0]  CTRL_OFFSET  = 8'd0;
    localparam logic [7:0]  BUF_OFFSET   = 8'd1;
    localparam int unsigned RX_FULL_BIT  = 0;
    localparam int unsigned TX_EMPTY_BIT = 1;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   pointer,
    input  logic         enable,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_idx,
    output logic         any_grant
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        if (enable) begin
            // k walks the priority order starting at the pointer, wrapping at N.
            for (int unsigned k = 0; k < N; k++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!any_grant && req[i] && (i == (32'(pointer) + k) % N)) begin
                        any_grant = 1'b1;
                        grant[i]  = 1'b1;
                        grant_idx = 3'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters: poll tx_empty, write buffer, kick control.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter logic [7:0]  UART_ADDRESS = 8'h00,
    parameter int unsigned POLL_GAP     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [7:0]           uart_address,
    output logic [7:0]           uart_din,
    output logic                 uart_w_en,
    output logic                 uart_r_en,
    input  logic [7:0]           uart_dout,
    output logic                 rx_pending,
    input  logic                 rx_ack
);

    state_t               state, next_state;
    logic [2:0]           ptr, nx_ptr;
    logic [7:0]           hold_byte, nx_hold;
    logic [7:2]           ctrl_shadow, nx_ctrl;
    logic [7:0]           gap_cnt, nx_gap;
    logic [NUM_REQ-1:0]   nx_ready;
    logic [2:0]           nx_grant_id;
    logic [7:0]           nx_addr, nx_din;
    logic                 nx_w, nx_r, rx_set;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [2:0]           arb_idx;
    logic                 arb_any;
    logic [7:0]           sel_byte;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .pointer   (ptr),
        .enable    (state == IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) sel_byte = sel_byte | req_data[8*i +: 8];
        end
    end

    always_comb begin
        next_state  = state;
        nx_ptr      = ptr;
        nx_hold     = hold_byte;
        nx_ctrl     = ctrl_shadow;
        nx_gap      = gap_cnt;
        nx_ready    = '0;
        nx_grant_id = grant_id;
        nx_addr     = '0;
        nx_din      = '0;
        nx_w        = 1'b0;
        nx_r        = 1'b0;
        rx_set      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    nx_ready    = arb_grant;
                    nx_hold     = sel_byte;
                    nx_grant_id = arb_idx;
                    nx_ptr      = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
                    next_state  = POLL_RD;
                end
            end
            POLL_RD: begin
                nx_addr    = UART_ADDRESS + CTRL_OFFSET;
                nx_r       = 1'b1;
                next_state = POLL_CHK;
            end
            POLL_CHK: begin
                // First cycle here carries the read strobe; data is valid only once it drops.
                if (!uart_r_en) begin
                    rx_set  = uart_dout[RX_FULL_BIT];
                    nx_ctrl = uart_dout[7:2];
                    if (uart_dout[TX_EMPTY_BIT]) begin
                        nx_addr    = UART_ADDRESS + BUF_OFFSET;
                        nx_din     = hold_byte;
                        nx_w       = 1'b1;
                        next_state = WR_BUF;
                    end else begin
                        nx_gap     = 8'(POLL_GAP);
                        next_state = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= 8'd1) begin
                    nx_gap     = '0;
                    next_state = POLL_RD;
                end else begin
                    nx_gap = gap_cnt - 8'd1;
                end
            end
            WR_BUF: begin
                nx_addr    = UART_ADDRESS + CTRL_OFFSET;
                nx_din     = {ctrl_shadow, 2'b00};
                nx_w       = 1'b1;
                next_state = WR_CTL;
            end
            WR_CTL: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_byte    <= '0;
            ctrl_shadow  <= '0;
            gap_cnt      <= '0;
            req_ready    <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            uart_address <= '0;
            uart_din     <= '0;
            uart_w_en    <= 1'b0;
            uart_r_en    <= 1'b0;
            rx_pending   <= 1'b0;
        end else begin
            state        <= next_state;
            ptr          <= nx_ptr;
            hold_byte    <= nx_hold;
            ctrl_shadow  <= nx_ctrl;
            gap_cnt      <= nx_gap;
            req_ready    <= nx_ready;
            grant_id     <= nx_grant_id;
            busy         <= (next_state != IDLE);
            uart_address <= nx_addr;
            uart_din     <= nx_din;
            uart_w_en    <= nx_w;
            uart_r_en    <= nx_r;
            if (rx_set)      rx_pending <= 1'b1;
            else if (rx_ack) rx_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a scripted UART control-register model.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [2:0]  grant_id;
    logic        busy;
    logic [7:0]  uart_address;
    logic [7:0]  uart_din;
    logic        uart_w_en;
    logic        uart_r_en;
    logic [7:0]  uart_dout = 8'h00;
    logic        rx_pending;
    logic        rx_ack;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    logic [7:0]  resp_q[$];

    int unsigned poll_cyc[4];
    int unsigned npoll, nbuf, nrdy, buf_cyc;
    logic [7:0]  buf_din;
    logic [1:0]  rdy_log[4];
    logic [7:0]  din_log[4];

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ      (2),
        .UART_ADDRESS (8'h00),
        .POLL_GAP     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .uart_address (uart_address),
        .uart_din     (uart_din),
        .uart_w_en    (uart_w_en),
        .uart_r_en    (uart_r_en),
        .uart_dout    (uart_dout),
        .rx_pending   (rx_pending),
        .rx_ack       (rx_ack)
    );

    // UART control register: returns scripted values, defaulting to tx_empty.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_r_en) begin
            if (resp_q.size() > 0) uart_dout <= resp_q.pop_front();
            else                   uart_dout <= 8'h02;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) step();
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; rx_ack = 1'b0;
        step(); step();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_strb",  32'({uart_w_en, uart_r_en}), 32'd0);
        check("rst_bus",   32'({uart_address, uart_din}), 32'd0);
        check("rst_rx",    32'(rx_pending), 32'd0);
        check("rst_gid",   32'(grant_id), 32'd0);
        rst_n = 1'b1;

        // Single request, UART idle
        req_data = 16'h0041; req_valid = 2'b01;
        step();
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_busy",  32'(busy), 32'd1);
        req_valid = '0;
        step();
        check("t1_rd",    32'({uart_r_en, uart_w_en, uart_address}), 32'h200);
        step();
        check("t1_quiet", 32'({uart_r_en, uart_w_en, uart_address, uart_din}), 32'h0);
        step();
        check("t1_wbuf",  32'({uart_w_en, uart_r_en, uart_address, uart_din}), 32'h20141);
        step();
        check("t1_wctl",  32'({uart_w_en, uart_r_en, uart_address, uart_din}), 32'h20000);
        step();
        check("t1_idle",  32'({busy, uart_w_en, uart_address, uart_din}), 32'h0);

        // Busy transmitter: three not-empty polls, then empty
        resp_q.push_back(8'h00); resp_q.push_back(8'h00);
        resp_q.push_back(8'h00); resp_q.push_back(8'h02);
        req_data = 16'h5A00; req_valid = 2'b10;
        step();
        check("t2_ready", 32'(req_ready), 32'h2);
        req_valid = '0;
        npoll = 0; nbuf = 0; buf_cyc = 0; buf_din = '0;
        for (int i = 0; i < 4; i++) poll_cyc[i] = 0;
        for (int i = 0; i < 120 && busy; i++) begin
            step();
            if (uart_r_en && npoll < 4) begin
                poll_cyc[npoll] = cyc;
                npoll++;
            end
            if (uart_w_en && uart_address == 8'h01) begin
                nbuf++;
                buf_din = uart_din;
                buf_cyc = cyc;
            end
        end
        check("t2_npoll", npoll, 32'd4);
        check("t2_gap1",  poll_cyc[1] - poll_cyc[0], 32'd19);
        check("t2_gap2",  poll_cyc[2] - poll_cyc[1], 32'd19);
        check("t2_gap3",  poll_cyc[3] - poll_cyc[2], 32'd19);
        check("t2_nbuf",  nbuf, 32'd1);
        check("t2_din",   32'(buf_din), 32'h5A);
        check("t2_wlat",  buf_cyc - poll_cyc[3], 32'd2);
        check("t2_idle",  32'(busy), 32'd0);

        // Fairness with both requesters continuously valid
        req_data = 16'hB0A0; req_valid = 2'b11;
        nrdy = 0; nbuf = 0;
        for (int i = 0; i < 4; i++) begin rdy_log[i] = '0; din_log[i] = '0; end
        for (int i = 0; i < 100 && nbuf < 4; i++) begin
            step();
            if (req_ready != 2'b00 && nrdy < 4) begin
                rdy_log[nrdy] = req_ready;
                nrdy++;
            end
            if (uart_w_en && uart_address == 8'h01) begin
                din_log[nbuf] = uart_din;
                nbuf++;
            end
        end
        req_valid = '0;
        check("t3_rdy", 32'({rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3]}), 32'h66);
        check("t3_din", {din_log[0], din_log[1], din_log[2], din_log[3]}, 32'hA0B0A0B0);
        wait_idle("t3_idle");

        // rx_full reported on the poll
        resp_q.push_back(8'h03);
        req_data = 16'h0011; req_valid = 2'b01;
        step();
        check("t4_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        step(); step(); step(); step();
        check("t4_wctl", 32'({uart_w_en, uart_address, uart_din}), 32'h10000);
        check("t4_rx",   32'(rx_pending), 32'd1);
        wait_idle("t4_idle");

        resp_q.push_back(8'h03);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        step(); step();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        check("t4_setwins", 32'(rx_pending), 32'd1);
        wait_idle("t4_idle2");
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        check("t4_ack", 32'(rx_pending), 32'd0);

        // Upper control bits survive the kick write
        resp_q.push_back(8'hF2);
        req_data = 16'h0077; req_valid = 2'b01;
        step();
        req_valid = '0;
        step(); step(); step();
        check("t5_wbuf", 32'({uart_w_en, uart_address, uart_din}), 32'h10177);
        step();
        check("t5_wctl", 32'({uart_w_en, uart_address, uart_din}), 32'h100F0);
        check("t5_rx",   32'(rx_pending), 32'd0);
        wait_idle("t5_idle");

        // Reset while waiting in GAP
        resp_q.push_back(8'h01);
        req_data = 16'h2211; req_valid = 2'b01;
        step();
        check("t6_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        step(); step(); step();
        check("t6_gap", 32'({busy, rx_pending, uart_w_en, uart_r_en}), 32'hC);
        rst_n = 1'b0;
        step();
        check("t6_rst",   32'({busy, rx_pending, uart_w_en, uart_r_en}), 32'h0);
        check("t6_rstrd", 32'({req_ready, uart_address, uart_din}), 32'h0);
        rst_n = 1'b1;
        req_valid = 2'b11;
        step();
        check("t6_ptr", 32'({grant_id, req_ready}), 32'h1);
        req_valid = '0;
        wait_idle("t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
